// File: rtl/mem_march_initiator.sv
// March-test initiator for the single-port valid/ready memory: write d(a), read d(a),
// write ~d(a), read ~d(a) over every address, reporting pass/fail, error count and timeout.
module mem_march_initiator #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      pattern,
  output logic                  mem_valid,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [1:0]            first_err_phase,
  output logic                  timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [TW-1:0]         LAST_WAIT = TW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [WIDTH-1:0]      pattern_q, pattern_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;

  logic                  mem_valid_d, mem_wr_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_d;
  logic                  busy_d, done_d, pass_d, timeout_err_d;
  logic [ADDR_WIDTH+1:0] err_count_d, err_next;
  logic [ADDR_WIDTH-1:0] first_err_addr_d, next_addr;
  logic [1:0]            first_err_phase_d, next_phase;
  logic                  miscmp;
  logic [WIDTH-1:0]      next_data;

  function automatic logic [WIDTH-1:0] data_of(input logic [WIDTH-1:0]      pat,
                                               input logic [ADDR_WIDTH-1:0] a);
    return pat ^ WIDTH'(a);
  endfunction

  // mem_wdata always carries the data value of the current transaction, so on a read it
  // is also the expected value for the compare.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d           = state_q;
    phase_d           = phase_q;
    pattern_d         = pattern_q;
    tcnt_d            = tcnt_q;
    mem_valid_d       = mem_valid;
    mem_wr_rd_d       = mem_wr_rd;
    mem_addr_d        = mem_addr;
    mem_wdata_d       = mem_wdata;
    busy_d            = busy;
    done_d            = done;
    pass_d            = pass;
    err_count_d       = err_count;
    first_err_addr_d  = first_err_addr;
    first_err_phase_d = first_err_phase;
    timeout_err_d     = timeout_err;
    miscmp            = 1'b0;
    err_next          = err_count;
    next_addr         = (mem_addr == LAST_ADDR) ? '0 : mem_addr + ADDR_WIDTH'(1);
    next_phase        = (mem_addr == LAST_ADDR) ? phase_q + 2'd1 : phase_q;
    next_data         = next_phase[1] ? ~data_of(pattern_q, next_addr)
                                      :  data_of(pattern_q, next_addr);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pattern_d         = pattern;
          busy_d            = 1'b1;
          done_d            = 1'b0;
          pass_d            = 1'b0;
          err_count_d       = '0;
          first_err_addr_d  = '0;
          first_err_phase_d = '0;
          timeout_err_d     = 1'b0;
          phase_d           = 2'd0;
          tcnt_d            = '0;
          mem_valid_d       = 1'b1;
          mem_wr_rd_d       = 1'b1;
          mem_addr_d        = '0;
          mem_wdata_d       = pattern;
          state_d           = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem_valid) begin
          mem_valid_d = 1'b0;
        end else if (mem_ready) begin
          miscmp      = !mem_wr_rd && (mem_rdata != mem_wdata);
          err_next    = err_count + (ADDR_WIDTH + 2)'(miscmp);
          err_count_d = err_next;
          if (miscmp && (err_count == '0)) begin
            first_err_addr_d  = mem_addr;
            first_err_phase_d = phase_q;
          end
          if ((phase_q == 2'd3) && (mem_addr == LAST_ADDR)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_next == '0);
            state_d = S_IDLE;
          end else begin
            phase_d     = next_phase;
            tcnt_d      = '0;
            mem_valid_d = 1'b1;
            mem_wr_rd_d = ~next_phase[0];
            mem_addr_d  = next_addr;
            mem_wdata_d = next_data;
          end
        end else if (tcnt_q == LAST_WAIT) begin
          timeout_err_d = 1'b1;
          done_d        = 1'b1;
          pass_d        = 1'b0;
          busy_d        = 1'b0;
          state_d       = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      phase_q         <= '0;
      pattern_q       <= '0;
      tcnt_q          <= '0;
      mem_valid       <= 1'b0;
      mem_wr_rd       <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_addr  <= '0;
      first_err_phase <= '0;
      timeout_err     <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      pattern_q       <= pattern_d;
      tcnt_q          <= tcnt_d;
      mem_valid       <= mem_valid_d;
      mem_wr_rd       <= mem_wr_rd_d;
      mem_addr        <= mem_addr_d;
      mem_wdata       <= mem_wdata_d;
      busy            <= busy_d;
      done            <= done_d;
      pass            <= pass_d;
      err_count       <= err_count_d;
      first_err_addr  <= first_err_addr_d;
      first_err_phase <= first_err_phase_d;
      timeout_err     <= timeout_err_d;
    end
  end

endmodule
